// File: rtl/rbm_pkg.sv
// Shared RBM definitions: write-channel FSM encoding and watchdog default.
// Fallback widths apply only when the core-level configuration macros are absent.
`ifndef NUM_HN_ONECORE
`define NUM_HN_ONECORE 4
`endif
`ifndef NUM_VN_ONECORE
`define NUM_VN_ONECORE 4
`endif
`ifndef BW_PS
`define BW_PS 8
`endif

package rbm_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } wch_tx_state_t;

    localparam int WCH_TIMEOUT_CYC_DEFAULT = 1023;

endpackage

// File: rtl/rbm_wch_watchdog.sv
// Cycle watchdog for the write channel: counts enabled busy cycles since the last
// state entry and flags the cycle in which the limit is reached.
module rbm_wch_watchdog #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic active,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Restart on every state change so each FSM state gets the full budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            if (!active || clear) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign expired = active && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/rbm_wch_tx.sv
// RBM write-channel transmitter: done/data/received handshake toward the arbiter,
// then per-neuron state collection. Optional watchdog under RBM_WCH_TIMEOUT_EN.
`ifndef NUM_HN_ONECORE
`define NUM_HN_ONECORE 4
`endif
`ifndef BW_PS
`define BW_PS 8
`endif

module rbm_wch_tx
    import rbm_pkg::*;
#(
    parameter int NUM_N       = `NUM_HN_ONECORE,
    parameter int BW_PS       = `BW_PS,
    parameter int TIMEOUT_CYC = WCH_TIMEOUT_CYC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [BW_PS*NUM_N-1:0] ps_in,
    output logic                   done,
    output logic [BW_PS*NUM_N-1:0] data,
    input  logic                   received,
    input  logic [NUM_N-1:0]       new_states,
    input  logic [NUM_N-1:0]       new_states_en,
    output logic [NUM_N-1:0]       states_out,
    output logic                   states_valid,
    output logic                   busy,
    output logic                   err_overrun,
    output logic                   err_timeout
);

    wch_tx_state_t    state;
    logic [NUM_N-1:0] mask;
    logic             all_done;
    logic             wd_expired;

    // Strobes arriving this cycle count toward completion.
    assign all_done = &(mask | new_states_en);

`ifdef RBM_WCH_TIMEOUT_EN
    logic wd_clear;

    assign wd_clear = ((state == TX_REQ) && received) ||
                      ((state == TX_WAIT) && all_done) ||
                      wd_expired;

    rbm_wch_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .active  (state != TX_IDLE),
        .clear   (wd_clear),
        .expired (wd_expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign wd_expired         = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= TX_IDLE;
            mask         <= '0;
            done         <= 1'b0;
            data         <= '0;
            states_out   <= '0;
            states_valid <= 1'b0;
            busy         <= 1'b0;
            err_overrun  <= 1'b0;
`ifdef RBM_WCH_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
        end else if (en) begin
            states_valid <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        data  <= ps_in;
                        mask  <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b1;
                        state <= TX_REQ;
                    end
                end
                TX_REQ, TX_WAIT: begin
                    // A repeated strobe simply overwrites that neuron's bit.
                    states_out <= (states_out & ~new_states_en) | (new_states & new_states_en);
                    mask       <= mask | new_states_en;
                    if (start) begin
                        err_overrun <= 1'b1;
                    end
                    if ((state == TX_REQ) && received) begin
                        done  <= 1'b0;
                        state <= TX_WAIT;
                    end else if ((state == TX_WAIT) && all_done) begin
                        states_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= TX_IDLE;
                    end else if (wd_expired) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= TX_IDLE;
`ifdef RBM_WCH_TIMEOUT_EN
                        err_timeout <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rbm_wch_tx.md
# rbm_wch_tx

Write-channel transmitter inside each RBM core; the initiator end of the done/data/received handshake that the per-row and per-column arbiters (`arbiter_vh` / `arbiter_hv`) answer. It captures one phase's packed partial sums, raises `done` with the data held stable until the arbiter pulses `received`, then collects the per-neuron new states returned by the AGS cores. When every neuron has reported, it presents the complete state vector to the core with a one-cycle valid pulse. One instance serves the v->h channel (`NUM_N` = `` `NUM_HN_ONECORE ``) and one serves the h->v channel (`NUM_N` = `` `NUM_VN_ONECORE ``).

## Interface
Parameters:
- `NUM_N`, default `` `NUM_HN_ONECORE ``: neurons carried per transfer.
- `BW_PS`, default `` `BW_PS ``: partial-sum width per neuron.
- `TIMEOUT_CYC`, default 1023: watchdog limit in cycles; only used with `RBM_WCH_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: global enable; when low, all registers hold.
- `start` in 1: single-cycle pulse from the core; `ps_in` is valid in that cycle.
- `ps_in` in `BW_PS*NUM_N`: packed partial sums; neuron i occupies `[BW_PS*(i+1)-1 : BW_PS*i]`.
- `done` out 1: request to the arbiter.
- `data` out `BW_PS*NUM_N`: captured partial sums, driven to the arbiter.
- `received` in 1: single-cycle acknowledge from the arbiter.
- `new_states` in `NUM_N`: per-neuron states returned from AGS.
- `new_states_en` in `NUM_N`: per-neuron strobes qualifying `new_states`.
- `states_out` out `NUM_N`: collected state vector.
- `states_valid` out 1: single-cycle pulse when `states_out` is complete.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err_overrun` out 1: sticky flag; set when `start` arrives while busy.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states are TX_IDLE, TX_REQ and TX_WAIT.
- **TX_IDLE**
  - On `start`: latch `ps_in` into `data`, clear the collected mask, set `done`=1, go to TX_REQ.
  - `received` and `new_states_en` are ignored in this state.
- **TX_REQ**
  - `done` and `data` are held constant.
  - On `received`: `done`=0, go to TX_WAIT.
- **State collection (TX_REQ and TX_WAIT)**
  - For each bit i with `new_states_en[i]`=1, write `new_states[i]` into `states_out[i]` and set mask bit i.
  - A repeated strobe on a bit overwrites its value; the mask bit stays set.
- **TX_WAIT completion**
  - When the mask, including strobes arriving this cycle, is all ones: pulse `states_valid` on the next cycle and go to TX_IDLE.
  - If the mask filled while in TX_REQ, completion happens on the first TX_WAIT cycle.
- **`start` while busy:** ignored, `err_overrun` is set, and the current transfer is not disturbed.
- **`en` low:** state, counters and outputs freeze, and every input, including pulses, is ignored.
- **Reset:** `rst` low mid-transfer aborts immediately and all outputs return to their reset values.
- **Arithmetic:** no arithmetic on partial sums; the data is a pure width-preserving copy.

## Timing
- **Reset values:** `done`=0, `data`=0, `states_out`=0, `states_valid`=0, `busy`=0, `err_overrun`=0, `err_timeout`=0, FSM in TX_IDLE, mask=0.
- **`start` at cycle t:** `done`=1, `busy`=1 and `data` are valid at t+1.
- **`received` at cycle r** (sampled only in TX_REQ): `done`=0 at r+1.
- **Last strobe at cycle s** (in TX_WAIT): `states_out` is final and `states_valid`=1 at s+1; `busy`=0 at s+1.
- **Back-to-back transfers:** `start` is accepted in the same cycle `states_valid` is high, since the FSM is already in TX_IDLE. Minimum turnaround from `states_valid` to the next `done` is 1 cycle.
- **`states_out` stability:** held between transfers; it is not cleared by a new `start`.

## Configuration
- **Macro `RBM_WCH_TIMEOUT_EN` defined:**
  - A counter resets on every state entry and increments each enabled cycle in TX_REQ/TX_WAIT.
  - On reaching `TIMEOUT_CYC`: set `err_timeout`, drop `done`, return to TX_IDLE with no `states_valid` pulse.
- **Macro not defined:** no counter is built, `err_timeout` is tied to 0, and the FSM waits indefinitely.

## Structure
- **Shared package `rbm_pkg`** holds:
  - `typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} wch_tx_state_t`.
  - The default `TIMEOUT_CYC` constant.
- **Sub-module `rbm_wch_watchdog`** (counter with a limit compare) is instantiated only under `RBM_WCH_TIMEOUT_EN`.
- The collection mask and the state vector stay in the top level.

## Test plan
All scenarios use `NUM_N`=4, `BW_PS`=8.
1. **Basic transfer:** reset, then `start` with `ps_in`=32'h11223344 → `done`=1, `data`=32'h11223344 next cycle. `received` 3 cycles later → `done`=0 the next cycle.
2. **State collection:** after `received`, strobes `new_states_en`=4'b0011/`new_states`=4'b0001, then 4'b1100/4'b1000 → `states_out`=4'b1001 and a single `states_valid` pulse one cycle after the second strobe; `busy`=0.
3. **Overrun:** `start` while in TX_REQ → `err_overrun`=1 and `data` unchanged. A stray `received` in TX_IDLE → no state change.
4. **Freeze and reset:** drop `en` for 5 cycles during TX_REQ with `received` pulsed → the pulse is ignored and `done` stays 1. Assert `rst` low mid-TX_WAIT → all outputs return to 0 asynchronously.
5. **Watchdog:** with `RBM_WCH_TIMEOUT_EN` and `TIMEOUT_CYC`=16, no `received` → `err_timeout`=1 and `done`=0 after 16 cycles in TX_REQ, with no `states_valid`.
6. **Early completion and back-to-back:** all 4 strobes arrive in TX_REQ, then `received` → `states_valid` on the first TX_WAIT cycle. `start` in that same cycle → accepted, `done`=1 the next cycle.
